// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter.
// Bytes written on wr are queued in a circular buffer. A three-state
// launcher pops one byte into din and pulses tx_start for one cycle. It
// then waits for tx_done before it offers the next byte.
// Optional feature macro: UART_TXF_OVF_EN adds the ovf/ovf_clr ports.
// ovf is a sticky flag that records writes dropped because the FIFO was full.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] din,
  input  logic              tx_done
`ifdef UART_TXF_OVF_EN
  ,
  input  logic              ovf_clr,
  output logic              ovf
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   mem_q [0:DEPTH-1];
  logic                push;
  logic                pop;
`ifdef UART_TXF_OVF_EN
  logic                ovf_q, ovf_d;
`endif

  // Flags come only from the registered count, so wr has no combinational path to them.
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign busy     = (state_q != IDLE) || !empty;
  assign tx_start = (state_q == LAUNCH);
  assign din      = din_q;

  // A full FIFO drops the write even when a pop frees a slot in the same cycle.
  assign push = wr && !full;
  assign pop  = (state_q == IDLE) && !empty;

  // Next-state logic for the pointers, the occupancy count, the output byte and the launcher.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    din_d   = din_q;
    state_d = state_q;

    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
      din_d  = mem_q[rptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE:    if (pop) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_TXF_OVF_EN
  // Sticky overflow: a dropped write sets the flag, and set wins over clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr && full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  assign ovf = ovf_q;
`endif

  // Control and output registers. Reset discards queued bytes and any launch in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      din_q   <= '0;
`ifdef UART_TXF_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      din_q   <= din_d;
`ifdef UART_TXF_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Storage array. It needs no reset because the count alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= w_data;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of each queued byte and of din.
REQ-002 Parameter ADDR_W, default 4, FIFO depth = 2**ADDR_W entries (16).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr  input  1  write strobe; one byte per cycle while high.
REQ-006 w_data  input  DATA_W  byte to queue.
REQ-007 full  output  1  FIFO holds 2**ADDR_W entries.
REQ-008 empty  output  1  FIFO holds 0 entries.
REQ-009 busy  output  1  high when FSM is not IDLE or FIFO is not empty.
REQ-010 tx_start  output  1  one-cycle launch pulse to the downstream UART transmitter.
REQ-011 din  output  DATA_W  byte presented to the transmitter; held stable from launch until the next pop.
REQ-012 tx_done  input  1  one-cycle completion pulse from the transmitter at the end of the stop bit.

Function
REQ-013 Storage is a circular buffer with write pointer, read pointer (ADDR_W bits, wrap 2**ADDR_W-1 -> 0) and occupancy count (ADDR_W+1 bits).
REQ-014 A write with wr=1 and full=0 stores w_data at the write pointer, increments it, and is visible (empty=0) the next cycle.
REQ-015 A write with full=1 is dropped, with no change to contents, pointers, or count, even if a pop occurs in the same cycle.
REQ-016 A pop occurs only in state IDLE with empty=0; it loads din from the read pointer and increments the read pointer.
REQ-017 A write and a pop in the same cycle leave the count unchanged.
REQ-018 full and empty are decoded from registered count with no combinational path from wr.
REQ-019 FSM states and transitions: IDLE -(empty=0, pop)-> LAUNCH; LAUNCH -> WAIT (unconditional); WAIT -(tx_done=1)-> IDLE.
REQ-020 tx_start is high exactly while the state is LAUNCH, decoded from the state register only.
REQ-021 tx_done is ignored in IDLE and LAUNCH.
REQ-022 Latency: a write to an empty FIFO in IDLE at cycle N produces tx_start high in cycle N+2.
REQ-023 Back-to-back: tx_done at cycle M with a non-empty FIFO produces the next tx_start in cycle M+2.
REQ-024 Bytes are launched in write order; no byte is launched twice or skipped.

Reset
REQ-025 While rst=1: state=IDLE, pointers=0, count=0, din=0, tx_start=0, empty=1, full=0, busy=0.
REQ-026 Reset mid-operation discards all queued bytes and any in-flight launch; the FSM does not wait for tx_done.

Configuration
REQ-027 Macro UART_TXF_OVF_EN, when defined, adds a sticky output ovf (1 bit) and an input ovf_clr (1 bit).
REQ-028 With UART_TXF_OVF_EN, ovf sets on any write with full=1 and clears on ovf_clr=1 or on reset.
REQ-029 With UART_TXF_OVF_EN, set has priority over clear when both occur in the same cycle.
REQ-030 Without UART_TXF_OVF_EN, neither port exists and dropped writes are silent.

Verification
REQ-031 Reset, then wr=1 with w_data=0xA5 at cycle N -> tx_start=1 only in cycle N+2, din=0xA5, empty=1 from N+2, busy=1 until tx_done.
REQ-032 Launch one byte and hold tx_done low; write 0x00..0x0F then 0xEE -> full=1 after 16th write, 0xEE dropped, ovf=1 (macro on).
REQ-033 From the REQ-032 state, return tx_done 2 cycles after each tx_start -> din sequence 0x00..0x0F, then empty=1, busy=0.
REQ-034 In IDLE with FIFO empty, pulse tx_done -> no state change, tx_start stays 0.
REQ-035 Assert rst in WAIT with 5 bytes queued -> empty=1, full=0, tx_start=0, din=0; a later tx_done causes no launch.
REQ-036 With ovf=1, pulse ovf_clr -> ovf=0; ovf_clr together with a full write -> ovf=1.
